apb_slot_arbiter: RTL and testbench

- Fabric-side controller that shares the MSS APB3 master port (MSSP* bus) among NUM_SLOTS fabric peripheral slots.
- Decodes the slot from MSSPADDR and re-times each transfer onto a registered downstream APB bus.
- Returns the selected slot's PRDATA/PSLVERR upstream and aborts hung slots with a bounded timeout.
- Sits between the MSS and fabric peripherals (LED drivers, GPI conditioners) in the top level.

---
 rtl/apb_slot_arbiter_if.sv | 40 ++++
 rtl/apb_slot_arbiter.sv | 174 +++++++++++++++++
 tb/tb_apb_slot_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slot_arbiter_if.sv
// rtl/apb_slot_arbiter_if.sv - MSS APB3 upstream and fabric slot downstream bus bundle
interface apb_slot_arbiter_if #(
  parameter int NUM_SLOTS    = 4,
  parameter int SLOT_SEL_LSB = 8
);
  // Upstream MSS APB3 port
  logic                      MSSPSEL;
  logic                      MSSPENABLE;
  logic                      MSSPWRITE;
  logic [19:0]               MSSPADDR;
  logic [31:0]               MSSPWDATA;
  logic [31:0]               MSSPRDATA;
  logic                      MSSPREADY;
  logic                      MSSPSLVERR;
  // Downstream shared slot bus
  logic [NUM_SLOTS-1:0]      S_PSEL;
  logic                      S_PENABLE;
  logic                      S_PWRITE;
  logic [SLOT_SEL_LSB-1:0]   S_PADDR;
  logic [31:0]               S_PWDATA;
  logic [32*NUM_SLOTS-1:0]   S_PRDATA;
  logic [NUM_SLOTS-1:0]      S_PREADY;
  logic [NUM_SLOTS-1:0]      S_PSLVERR;

  // Arbiter view: completer on the MSS side, requester on the slot side
  modport slave (
    input  MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR, MSSPWDATA,
    output MSSPRDATA, MSSPREADY, MSSPSLVERR,
    output S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA,
    input  S_PRDATA, S_PREADY, S_PSLVERR
  );

  // Environment view: MSS master plus the slot peripherals
  modport master (
    output MSSPSEL, MSSPENABLE, MSSPWRITE, MSSPADDR, MSSPWDATA,
    input  MSSPRDATA, MSSPREADY, MSSPSLVERR,
    input  S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA,
    output S_PRDATA, S_PREADY, S_PSLVERR
  );
endinterface

// File: rtl/apb_slot_arbiter.sv
// rtl/apb_slot_arbiter.sv - shares the MSS APB3 port among fabric slots; optional abort timer via APB_SLOT_ARBITER_TIMEOUT_EN
module apb_slot_arbiter #(
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_SEL_LSB   = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  SYSCLK,
  input  logic                  NSYSRESET,
  apb_slot_arbiter_if.slave     bus,
  output logic                  TIMEOUT_IRQ,
  output logic [7:0]            TIMEOUT_CNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                  state_q;
  logic [2:0]              idx_q;
  logic [NUM_SLOTS-1:0]    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [SLOT_SEL_LSB-1:0] paddr_q;
  logic [31:0]             pwdata_q;
  logic [31:0]             rdata_q;
  logic                    slverr_q;
  logic                    ready_q;

  logic [2:0]              idx_d;
  logic                    idx_valid_d;
  logic [NUM_SLOTS-1:0]    onehot_d;
  logic                    sel_ready_d;
  logic                    sel_err_d;
  logic [31:0]             sel_rdata_d;

`ifdef APB_SLOT_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q;
  logic [7:0] tcnt_q;
  logic       irq_q;
`endif

  // Slot index decode of the incoming setup address and its one-hot select
  always_comb begin
    idx_d       = bus.MSSPADDR[SLOT_SEL_LSB+2:SLOT_SEL_LSB];
    idx_valid_d = (int'(idx_d) < NUM_SLOTS);
    onehot_d    = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      onehot_d[k] = (idx_d == 3'(k));
    end
  end

  // Response mux: only the latched slot's ready/error/data are observed
  always_comb begin
    sel_ready_d = 1'b0;
    sel_err_d   = 1'b0;
    sel_rdata_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (idx_q == 3'(k)) begin
        sel_ready_d = bus.S_PREADY[k];
        sel_err_d   = bus.S_PSLVERR[k];
        sel_rdata_d = bus.S_PRDATA[32*k +: 32];
      end
    end
  end

  // Transfer FSM with registered upstream and downstream outputs
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      ready_q   <= 1'b0;
`ifdef APB_SLOT_ARBITER_TIMEOUT_EN
      tmo_q     <= '0;
      tcnt_q    <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      // Response fields are only non-zero during the single RESP cycle
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
`ifdef APB_SLOT_ARBITER_TIMEOUT_EN
      irq_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.MSSPSEL && !bus.MSSPENABLE) begin
            idx_q <= idx_d;
            if (idx_valid_d) begin
              state_q  <= SETUP;
              psel_q   <= onehot_d;
              pwrite_q <= bus.MSSPWRITE;
              paddr_q  <= bus.MSSPADDR[SLOT_SEL_LSB-1:0];
              pwdata_q <= bus.MSSPWDATA;
            end else begin
              // Unmapped slot: error straight back, slot bus untouched
              state_q  <= RESP;
              ready_q  <= 1'b1;
              slverr_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_SLOT_ARBITER_TIMEOUT_EN
          tmo_q     <= '0;
`endif
        end
        ACCESS: begin
          // Ready wins over a coincident timeout
          if (sel_ready_d) begin
            state_q   <= RESP;
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b1;
            rdata_q   <= sel_rdata_d;
            slverr_q  <= sel_err_d;
          end
`ifdef APB_SLOT_ARBITER_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q   <= RESP;
            psel_q    <= '0;
            penable_q <= 1'b0;
            ready_q   <= 1'b1;
            slverr_q  <= 1'b1;
            irq_q     <= 1'b1;
            if (tcnt_q != 8'hFF) begin
              tcnt_q <= tcnt_q + 8'd1;
            end
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.S_PSEL     = psel_q;
  assign bus.S_PENABLE  = penable_q;
  assign bus.S_PWRITE   = pwrite_q;
  assign bus.S_PADDR    = paddr_q;
  assign bus.S_PWDATA   = pwdata_q;
  assign bus.MSSPRDATA  = rdata_q;
  assign bus.MSSPSLVERR = slverr_q;
  assign bus.MSSPREADY  = ready_q;

`ifdef APB_SLOT_ARBITER_TIMEOUT_EN
  assign TIMEOUT_IRQ = irq_q;
  assign TIMEOUT_CNT = tcnt_q;
`else
  assign TIMEOUT_IRQ = 1'b0;
  assign TIMEOUT_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_apb_slot_arbiter.sv
// tb/tb_apb_slot_arbiter.sv - scoreboard bench for apb_slot_arbiter
module tb_apb_slot_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irq;
  logic [7:0] tcnt;

  apb_slot_arbiter_if #(.NUM_SLOTS(4), .SLOT_SEL_LSB(8)) bus ();

  apb_slot_arbiter #(
    .NUM_SLOTS(4),
    .SLOT_SEL_LSB(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .SYSCLK(clk),
    .NSYSRESET(rst_n),
    .bus(bus.slave),
    .TIMEOUT_IRQ(irq),
    .TIMEOUT_CNT(tcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  sel;
    logic [7:0]  paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Slot models: selected slot becomes ready after wait_cfg cycles; idle slots
  // drive ready/error high so a broken response mux shows up.
  logic [15:0] wait_cfg [4];
  logic [3:0]  err_cfg;
  logic [15:0] wcnt = '0;
  logic [3:0]  rdy_v;
  logic [3:0]  err_v;

  always_comb begin
    rdy_v = '0;
    err_v = '0;
    for (int k = 0; k < 4; k++) begin
      rdy_v[k] = bus.S_PSEL[k] ? (bus.S_PENABLE && (wcnt == wait_cfg[k])) : 1'b1;
      err_v[k] = bus.S_PSEL[k] ? err_cfg[k] : 1'b1;
    end
  end

  assign bus.S_PREADY  = rdy_v;
  assign bus.S_PSLVERR = err_v;
  assign bus.S_PRDATA  = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

  always @(posedge clk) begin
    if (bus.S_PENABLE && (bus.S_PSEL != 4'b0) && ((bus.S_PSEL & rdy_v) == 4'b0))
      wcnt <= wcnt + 16'd1;
    else
      wcnt <= '0;
  end

  // Downstream observer: records each access phase start
  int          obs_cnt = 0;
  int          irq_n   = 0;
  logic        pen_prev = 1'b0;
  logic [3:0]  obs_sel;
  logic [7:0]  obs_paddr;
  logic        obs_pwrite;
  logic [31:0] obs_pwdata;

  always @(negedge clk) begin
    pen_prev <= bus.S_PENABLE;
    if (bus.S_PENABLE && !pen_prev) begin
      obs_cnt    <= obs_cnt + 1;
      obs_sel    <= bus.S_PSEL;
      obs_paddr  <= bus.S_PADDR;
      obs_pwrite <= bus.S_PWRITE;
      obs_pwdata <= bus.S_PWDATA;
    end
    if (irq) irq_n <= irq_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expected);
    total++;
    if (got !== expected) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, expected, $time);
    end
  endtask

  task automatic xfer(input logic [19:0] a, input logic w, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int el, input bit abandon);
    exp_t       e;
    exp_t       g;
    int         lat;
    bit         got;
    int         n0;
    logic [2:0] idx;
    idx      = a[10:8];
    e.rdata  = er;
    e.err    = ee;
    e.lat    = el;
    e.sel    = (idx < 3'd4) ? (4'b0001 << idx) : 4'b0000;
    e.paddr  = a[7:0];
    e.pwrite = w;
    e.pwdata = wd;
    sb.push_back(e);
    n0 = obs_cnt;
    @(posedge clk); #1;
    bus.MSSPSEL    = 1'b1;
    bus.MSSPENABLE = 1'b0;
    bus.MSSPADDR   = a;
    bus.MSSPWRITE  = w;
    bus.MSSPWDATA  = wd;
    @(negedge clk);
    check("rdy_in_setup", bus.MSSPREADY, 1'b0);
    check("rdata_in_setup", bus.MSSPRDATA, 32'h0);
    @(posedge clk); #1;
    if (abandon) bus.MSSPSEL = 1'b0;
    else bus.MSSPENABLE = 1'b1;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 2000) begin
      @(negedge clk);
      if (bus.MSSPREADY) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("ready_seen", got, 1'b1);
    g = sb.pop_front();
    check("rdata", bus.MSSPRDATA, g.rdata);
    check("slverr", bus.MSSPSLVERR, g.err);
    check("latency", lat, g.lat);
    check("dn_accesses", obs_cnt - n0, (g.sel != 4'b0) ? 1 : 0);
    if (g.sel != 4'b0) begin
      check("s_psel", obs_sel, g.sel);
      check("s_paddr", obs_paddr, g.paddr);
      check("s_pwrite", obs_pwrite, g.pwrite);
      check("s_pwdata", obs_pwdata, g.pwdata);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.MSSPSEL    = 1'b0;
    bus.MSSPENABLE = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.MSSPSEL    = 1'b0;
    bus.MSSPENABLE = 1'b0;
    bus.MSSPWRITE  = 1'b0;
    bus.MSSPADDR   = '0;
    bus.MSSPWDATA  = '0;
    for (int k = 0; k < 4; k++) wait_cfg[k] = 16'd0;
    err_cfg = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.MSSPREADY, 1'b0);
    check("rst_psel", bus.S_PSEL, 4'b0);
    check("rst_penable", bus.S_PENABLE, 1'b0);
    check("rst_rdata", bus.MSSPRDATA, 32'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_tcnt", tcnt, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Zero-wait read of slot 1
    xfer(20'h00104, 1'b0, 32'h0, 32'hCAFE0001, 1'b0, 3, 1'b0);
    idle(1);
    // Write slot 3 with 5 wait cycles
    wait_cfg[3] = 16'd5;
    xfer(20'h00310, 1'b1, 32'h12345678, 32'hCAFE0003, 1'b0, 8, 1'b0);
    idle(1);
    wait_cfg[3] = 16'd0;
    // Unmapped slot 5
    xfer(20'h00500, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1, 1, 1'b0);
    idle(1);
    // Slot error then a back-to-back read
    err_cfg[0] = 1'b1;
    xfer(20'h00020, 1'b0, 32'h0, 32'hCAFE0000, 1'b1, 3, 1'b0);
    xfer(20'h00104, 1'b0, 32'h0, 32'hCAFE0001, 1'b0, 3, 1'b0);
    idle(1);
    err_cfg[0] = 1'b0;
    // Master abandons after setup; downstream still completes
    wait_cfg[1] = 16'd2;
    xfer(20'h00108, 1'b0, 32'h0, 32'hCAFE0001, 1'b0, 5, 1'b1);
    idle(2);
    wait_cfg[1] = 16'd0;

`ifdef APB_SLOT_ARBITER_TIMEOUT_EN
    wait_cfg[2] = 16'hFFFF;
    xfer(20'h00200, 1'b0, 32'h0, 32'h0, 1'b1, 18, 1'b0);
    idle(1);
    check("irq_pulses_1", irq_n, 1);
    check("tcnt_1", tcnt, 8'd1);
    // Ready on the final allowed cycle is a success
    wait_cfg[3] = 16'd15;
    xfer(20'h00300, 1'b0, 32'h0, 32'hCAFE0003, 1'b0, 18, 1'b0);
    idle(1);
    check("irq_edge_none", irq_n, 1);
    check("tcnt_edge", tcnt, 8'd1);
    wait_cfg[3] = 16'd0;
    for (int i = 0; i < 299; i++) begin
      xfer(20'h00200, 1'b0, 32'h0, 32'h0, 1'b1, 18, 1'b0);
    end
    idle(1);
    check("irq_pulses_300", irq_n, 300);
    check("tcnt_sat", tcnt, 8'd255);
`else
    wait_cfg[2] = 16'd300;
    xfer(20'h00200, 1'b0, 32'h0, 32'hCAFE0002, 1'b0, 303, 1'b0);
    idle(1);
    check("irq_off", irq_n, 0);
    check("tcnt_off", tcnt, 8'd0);
`endif

    // Asynchronous reset while in ACCESS
    wait_cfg[2] = 16'hFFFF;
    @(posedge clk); #1;
    bus.MSSPSEL    = 1'b1;
    bus.MSSPENABLE = 1'b0;
    bus.MSSPADDR   = 20'h00200;
    bus.MSSPWRITE  = 1'b0;
    @(posedge clk); #1;
    bus.MSSPENABLE = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_penable", bus.S_PENABLE, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_psel", bus.S_PSEL, 4'b0);
    check("arst_penable", bus.S_PENABLE, 1'b0);
    check("arst_ready", bus.MSSPREADY, 1'b0);
    check("arst_tcnt", tcnt, 8'd0);
    bus.MSSPSEL    = 1'b0;
    bus.MSSPENABLE = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cfg[2] = 16'd0;
    idle(1);
    xfer(20'h00204, 1'b0, 32'h0, 32'hCAFE0002, 1'b0, 3, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
